// File: rtl/dr_pkg.sv
// Shared definitions for the dual-rail up/down counter.
//   DR_*      : dual-rail pair codewords, encoded {t,f}
//   state_t   : handshake state of the counter
//   pair_dec_t: decoded view of one dual-rail pair
//   CMD_*     : index of each command pair in the packed command vectors
package dr_pkg;

   localparam logic [1:0] DR_NULL = 2'b00;
   localparam logic [1:0] DR_ZERO = 2'b01;
   localparam logic [1:0] DR_ONE  = 2'b10;
   localparam logic [1:0] DR_ILL  = 2'b11;

   localparam int NUM_CMD  = 3;
   localparam int CMD_CLR  = 0;
   localparam int CMD_EN   = 1;
   localparam int CMD_DOWN = 2;

   typedef enum logic [1:0] {
      S_NULL = 2'd0,
      S_DATA = 2'd1,
      S_ERR  = 2'd2
   } state_t;

   typedef struct packed {
      logic is_null;  // spacer
      logic val;      // logic value, meaningful only when neither null nor illegal
      logic ill;      // both rails high
   } pair_dec_t;

endpackage

// File: rtl/dr_pair_decode.sv
// Decodes one dual-rail pair into null / value / illegal.
//   t, f : true and false rail of the pair
//   dec  : decoded pair (is_null, val, ill)
module dr_pair_decode
   import dr_pkg::*;
(
   input  logic      t,
   input  logic      f,
   output pair_dec_t dec
);

   always_comb begin
      dec.is_null = ({t, f} == DR_NULL);
      dec.val     = ({t, f} == DR_ONE);
      dec.ill     = ({t, f} == DR_ILL);
   end

endmodule

// File: rtl/dr_updown_counter.sv
// Clocked dual-rail up/down counter with a four-phase return-to-zero
// handshake. One count update per handshake; result returned as dual-rail
// data plus a dual-rail terminal-count flag.
//   clk, reset            : clock, synchronous active-high reset
//   ackin                 : sender request (1 = data phase, 0 = spacer)
//   t_/f_clr,enable,down  : dual-rail commands
//   t_out, f_out          : dual-rail count (both zero in spacer)
//   t_tc, f_tc            : dual-rail terminal-count flag
//   ackout                : 1 = ready for data, 0 = data delivered
//   err                   : illegal codeword seen
module dr_updown_counter
   import dr_pkg::*;
#(
   parameter int               WIDTH    = 8,
   parameter bit               SATURATE = 1'b0,
   parameter logic [WIDTH-1:0] CLR_VAL  = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ackin,
   input  logic             t_clr,
   input  logic             f_clr,
   input  logic             t_enable,
   input  logic             f_enable,
   input  logic             t_down,
   input  logic             f_down,
   output logic [WIDTH-1:0] t_out,
   output logic [WIDTH-1:0] f_out,
   output logic             t_tc,
   output logic             f_tc,
   output logic             ackout,
   output logic             err
);

   logic [NUM_CMD-1:0] t_cmd, f_cmd;
   pair_dec_t          dec [NUM_CMD];

   assign t_cmd = {t_down, t_enable, t_clr};
   assign f_cmd = {f_down, f_enable, f_clr};

   for (genvar i = 0; i < NUM_CMD; i++) begin : g_dec
      dr_pair_decode u_dec (
         .t   (t_cmd[i]),
         .f   (f_cmd[i]),
         .dec (dec[i])
      );
   end

   logic any_ill, all_null, complete;

   always_comb begin
      any_ill  = 1'b0;
      all_null = 1'b1;
      for (int i = 0; i < NUM_CMD; i++) begin
         any_ill  = any_ill | dec[i].ill;
         all_null = all_null & dec[i].is_null;
      end
      complete = ~any_ill;
      for (int i = 0; i < NUM_CMD; i++)
         complete = complete & ~dec[i].is_null;
   end

   // Next count and terminal-count; clear outranks enable.
   logic [WIDTH-1:0] cnt_q, nxt;
   logic             nxt_tc;

   always_comb begin
      nxt    = cnt_q;
      nxt_tc = 1'b0;
      if (dec[CMD_CLR].val) begin
         nxt = CLR_VAL;
      end else if (dec[CMD_EN].val) begin
         if (!dec[CMD_DOWN].val) begin
            if (&cnt_q) begin
               nxt_tc = 1'b1;
               nxt    = SATURATE ? cnt_q : '0;
            end else begin
               nxt = cnt_q + 1'b1;
            end
         end else begin
            if (~|cnt_q) begin
               nxt_tc = 1'b1;
               nxt    = SATURATE ? '0 : '1;
            end else begin
               nxt = cnt_q - 1'b1;
            end
         end
      end
   end

   // Handshake FSM: every output is computed here and registered below,
   // so nothing reaches an output port combinationally.
   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_d, t_out_d, f_out_d;
   logic             t_tc_d, f_tc_d, ackout_d, err_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      t_out_d  = t_out;
      f_out_d  = f_out;
      t_tc_d   = t_tc;
      f_tc_d   = f_tc;
      ackout_d = ackout;
      err_d    = err;
      unique case (state_q)
         S_NULL: begin
            if (ackin && any_ill) begin
               state_d = S_ERR;
               err_d   = 1'b1;
            end else if (ackin && complete) begin
               state_d  = S_DATA;
               cnt_d    = nxt;
               t_out_d  = nxt;
               f_out_d  = ~nxt;
               t_tc_d   = nxt_tc;
               f_tc_d   = ~nxt_tc;
               ackout_d = 1'b0;
            end
         end
         S_DATA: begin
            // Outputs stay frozen; a held ackin never triggers a second count.
            if (any_ill) err_d = 1'b1;
            if (!ackin && all_null) begin
               state_d  = S_NULL;
               t_out_d  = '0;
               f_out_d  = '0;
               t_tc_d   = 1'b0;
               f_tc_d   = 1'b0;
               ackout_d = 1'b1;
               err_d    = 1'b0;
            end
         end
         S_ERR: begin
            if (!ackin && all_null) begin
               state_d = S_NULL;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d  = S_NULL;
            t_out_d  = '0;
            f_out_d  = '0;
            t_tc_d   = 1'b0;
            f_tc_d   = 1'b0;
            ackout_d = 1'b1;
            err_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_NULL;
         cnt_q   <= CLR_VAL;
         t_out   <= '0;
         f_out   <= '0;
         t_tc    <= 1'b0;
         f_tc    <= 1'b0;
         ackout  <= 1'b1;
         err     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         t_out   <= t_out_d;
         f_out   <= f_out_d;
         t_tc    <= t_tc_d;
         f_tc    <= f_tc_d;
         ackout  <= ackout_d;
         err     <= err_d;
      end
   end

endmodule

// File: tb/tb_dr_updown_counter.sv
// Directed bench for dr_updown_counter: a wrap instance (CLR_VAL 0) and a
// saturate instance (CLR_VAL 8'hFD) share the same stimulus.
module tb_dr_updown_counter;

   logic clk = 1'b0, reset = 1'b1, ackin = 1'b0;
   logic t_clr = 0, f_clr = 0, t_enable = 0, f_enable = 0, t_down = 0, f_down = 0;
   logic [7:0] t_out_w, f_out_w, t_out_s, f_out_s;
   logic t_tc_w, f_tc_w, ackout_w, err_w, t_tc_s, f_tc_s, ackout_s, err_s;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   dr_updown_counter #(.WIDTH(8), .SATURATE(1'b0), .CLR_VAL(8'h00)) u_wrap (
      .clk(clk), .reset(reset), .ackin(ackin),
      .t_clr(t_clr), .f_clr(f_clr), .t_enable(t_enable), .f_enable(f_enable),
      .t_down(t_down), .f_down(f_down),
      .t_out(t_out_w), .f_out(f_out_w), .t_tc(t_tc_w), .f_tc(f_tc_w),
      .ackout(ackout_w), .err(err_w));

   dr_updown_counter #(.WIDTH(8), .SATURATE(1'b1), .CLR_VAL(8'hFD)) u_sat (
      .clk(clk), .reset(reset), .ackin(ackin),
      .t_clr(t_clr), .f_clr(f_clr), .t_enable(t_enable), .f_enable(f_enable),
      .t_down(t_down), .f_down(f_down),
      .t_out(t_out_s), .f_out(f_out_s), .t_tc(t_tc_s), .f_tc(f_tc_s),
      .ackout(ackout_s), .err(err_s));

   typedef struct {
      logic       clr, en, down;
      logic [7:0] ew;   // expected wrap count
      logic       etw;  // expected wrap tc
      logic [7:0] es;   // expected saturate count
      logic       ets;  // expected saturate tc
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(input logic clr, input logic en, input logic down);
      t_clr = clr;  f_clr = ~clr;
      t_enable = en; f_enable = ~en;
      t_down = down; f_down = ~down;
   endtask

   task automatic set_null();
      t_clr = 0; f_clr = 0; t_enable = 0; f_enable = 0; t_down = 0; f_down = 0;
   endtask

   task automatic chk_spacer(input string nm);
      chk({nm, " w rails"}, {t_out_w | f_out_w, 6'b0, t_tc_w, f_tc_w}, 0);
      chk({nm, " s rails"}, {t_out_s | f_out_s, 6'b0, t_tc_s, f_tc_s}, 0);
      chk({nm, " ackout"}, {ackout_w, ackout_s}, 2'b11);
   endtask

   task automatic chk_data(input string nm, input logic [7:0] ew, input logic etw,
                           input logic [7:0] es, input logic ets);
      logic [7:0] fw, fs;
      fw = ~ew;
      fs = ~es;
      chk({nm, " w t_out"}, t_out_w, ew);
      chk({nm, " w f_out"}, f_out_w, fw);
      chk({nm, " w tc"}, {t_tc_w, f_tc_w}, {etw, ~etw});
      chk({nm, " s t_out"}, t_out_s, es);
      chk({nm, " s f_out"}, f_out_s, fs);
      chk({nm, " s tc"}, {t_tc_s, f_tc_s}, {ets, ~ets});
      chk({nm, " ackout"}, {ackout_w, ackout_s}, 2'b00);
   endtask

   task automatic hs(input logic clr, input logic en, input logic down,
                     input logic [7:0] ew, input logic etw,
                     input logic [7:0] es, input logic ets, input string nm);
      set_cmd(clr, en, down);
      ackin = 1'b1;
      tick();
      chk_data(nm, ew, etw, es, ets);
      ackin = 1'b0;
      set_null();
      tick();
      chk_spacer({nm, " spacer"});
   endtask

   initial begin
      //        clr en dn  wrap     tc  sat      tc
      vecs[0]  = '{0, 1, 0, 8'h01, 0, 8'hFE, 0};
      vecs[1]  = '{0, 1, 0, 8'h02, 0, 8'hFF, 0};
      vecs[2]  = '{0, 1, 0, 8'h03, 0, 8'hFF, 1};
      vecs[3]  = '{0, 1, 0, 8'h04, 0, 8'hFF, 1};
      vecs[4]  = '{0, 1, 0, 8'h05, 0, 8'hFF, 1};
      vecs[5]  = '{1, 1, 0, 8'h00, 0, 8'hFD, 0};
      vecs[6]  = '{0, 1, 1, 8'hFF, 1, 8'hFC, 0};
      vecs[7]  = '{0, 1, 0, 8'h00, 1, 8'hFD, 0};
      vecs[8]  = '{0, 0, 0, 8'h00, 0, 8'hFD, 0};
      vecs[9]  = '{0, 1, 1, 8'hFF, 1, 8'hFC, 0};
      vecs[10] = '{1, 1, 1, 8'h00, 0, 8'hFD, 0};
      vecs[11] = '{0, 1, 1, 8'hFF, 1, 8'hFC, 0};

      tick();
      tick();
      chk_spacer("reset");
      chk("reset err", {err_w, err_s}, 2'b00);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 12; i++)
         hs(vecs[i].clr, vecs[i].en, vecs[i].down, vecs[i].ew, vecs[i].etw,
            vecs[i].es, vecs[i].ets, $sformatf("vec%0d", i));

      // Illegal clear pair during request: error, no count, recover.
      t_clr = 1; f_clr = 1; t_enable = 1; f_enable = 0; t_down = 0; f_down = 1;
      ackin = 1'b1;
      tick();
      tick();
      chk("ill err", {err_w, err_s}, 2'b11);
      chk_spacer("ill");
      ackin = 1'b0;
      set_null();
      tick();
      chk("ill recover err", {err_w, err_s}, 2'b00);
      hs(0, 1, 0, 8'h00, 1, 8'hFD, 0, "after ill");

      // Partial command: enable pair null keeps the counter idle.
      t_clr = 0; f_clr = 1; t_enable = 0; f_enable = 0; t_down = 0; f_down = 1;
      ackin = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("partial idle", {ackout_w, t_out_w}, {1'b1, 8'h00});
      end
      t_enable = 1; f_enable = 0;
      tick();
      chk_data("partial done", 8'h01, 0, 8'hFE, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("held ackin", {ackout_w, t_out_w, t_out_s}, {1'b0, 8'h01, 8'hFE});
      end
      ackin = 1'b0;
      tick();
      chk("cmds not null", {ackout_w, t_out_w}, {1'b0, 8'h01});
      set_null();
      tick();
      chk_spacer("partial spacer");
      hs(0, 1, 0, 8'h02, 0, 8'hFF, 0, "single step");

      // Illegal pair inside the data phase: flag only.
      set_cmd(0, 1, 0);
      ackin = 1'b1;
      tick();
      chk_data("pre data-ill", 8'h03, 0, 8'hFF, 1);
      t_enable = 1; f_enable = 1;
      tick();
      chk("data-ill err", {err_w, err_s}, 2'b11);
      chk("data-ill hold", {ackout_w, t_out_w, f_out_w}, {1'b0, 8'h03, 8'hFC});
      ackin = 1'b0;
      set_null();
      tick();
      chk("data-ill clear err", {err_w, err_s}, 2'b00);
      chk_spacer("data-ill spacer");

      // Reset mid-handshake with the count showing 8'h07.
      hs(0, 1, 0, 8'h04, 0, 8'hFF, 1, "to7 a");
      hs(0, 1, 0, 8'h05, 0, 8'hFF, 1, "to7 b");
      hs(0, 1, 0, 8'h06, 0, 8'hFF, 1, "to7 c");
      set_cmd(0, 1, 0);
      ackin = 1'b1;
      tick();
      chk_data("at7", 8'h07, 0, 8'hFF, 1);
      reset = 1'b1;
      tick();
      chk_spacer("mid reset");
      chk("mid reset err", {err_w, err_s}, 2'b00);
      reset = 1'b0;
      ackin = 1'b0;
      set_null();
      tick();
      hs(0, 1, 0, 8'h01, 0, 8'hFE, 0, "post reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dr_updown_counter.md
Name: dr_updown_counter

Overview:
Clocked, parametrised successor to the team's dual-rail handshake counter. It takes dual-rail commands (clear, enable, direction) under a four-phase return-to-zero handshake and returns the counter value as dual-rail data (true rail / false rail), plus a dual-rail terminal-count flag. New relative to the previous generation:
- generic width
- up/down counting
- wrap or saturate mode
- programmable clear value
- illegal-codeword detection
It sits between dual-rail producer/consumer stages in the NTU async-style datapath, now sampled on a single clock.

Parameters:
WIDTH, 8, counter and data-rail width (>=2)
SATURATE, 0, 0 = wrap modulo 2^WIDTH; 1 = hold at the bound
CLR_VAL, 0, value loaded on reset and on a clear command (WIDTH bits)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
ackin  in  1  four-phase request from the sender (1 = data phase, 0 = spacer)
t_clr, f_clr  in  1 each  dual-rail clear command
t_enable, f_enable  in  1 each  dual-rail count-enable command
t_down, f_down  in  1 each  dual-rail direction (true = decrement)
t_out  out  WIDTH  true rail of the count
f_out  out  WIDTH  false rail (~count in data phase)
t_tc, f_tc  out  1 each  dual-rail terminal-count flag
ackout  out  1  acknowledge (1 = ready for data, 0 = data delivered)
err  out  1  illegal codeword seen

Behaviour:
- One clock; reset is synchronous and active-high. The ports are named clk and reset.
- Reset, applied in any state including mid-handshake, takes effect at the next edge:
  - count = CLR_VAL
  - t_out = f_out = 0, t_tc = f_tc = 0
  - ackout = 1, err = 0
  - state = S_NULL
- Pair decode per command (t,f):
  - 00 = null
  - 10 = logic 1
  - 01 = logic 0
  - 11 = illegal
- Commands are complete when all three pairs are non-null and none is illegal.
- S_NULL (ackout = 1, all output rails 0):
  - ackin = 1, any pair illegal -> S_ERR. err = 1 next cycle; count unchanged.
  - ackin = 1, complete -> S_DATA. Next edge: count = nxt, t_out = nxt, f_out = ~nxt, tc rails driven, ackout = 0. Latency is 1 cycle from the sampling edge.
  - ackin = 1, incomplete -> stay; no update.
- Next-count rules, with priority clr > enable:
  - clr = 1: nxt = CLR_VAL; tc = 0.
  - enable = 0: nxt = count; tc = 0.
  - Up, not at max: nxt = count+1; tc = 0.
  - Up, at max (2^WIDTH-1): wrap mode gives nxt = 0; saturate mode gives nxt = max. tc = 1 in both modes.
  - Down at 0: wrap mode gives nxt = max; saturate mode gives nxt = 0. tc = 1.
  - Arithmetic is unsigned, WIDTH bits, with no carry out.
  - tc = 1 drives t_tc = 1, f_tc = 0; tc = 0 drives t_tc = 0, f_tc = 1.
- S_DATA (ackout = 0, outputs held stable):
  - Waits for ackin = 0 AND all command pairs null, then -> S_NULL. Next edge: all rails 0, ackout = 1.
  - ackin = 0 with commands not yet null: stay.
  - ackin = 1 held: stay; no second update, one count per handshake.
  - An illegal pair appearing in S_DATA sets err = 1 but does not change the state or outputs.
- S_ERR (ackout = 1, output rails 0, err = 1):
  - Leaves only when ackin = 0 and all pairs are null -> S_NULL with err = 0.
- Output rails are never both 1 in the same bit. In S_NULL and S_ERR, t_out | f_out = 0. In S_DATA, t_out ^ f_out = all ones.
- All outputs are registered; no combinational path from input to output.

Decomposition:
- Shared package dr_pkg:
  - DR_NULL = 2'b00, DR_ZERO = 2'b01, DR_ONE = 2'b10, DR_ILL = 2'b11 (encoding {t,f})
  - state enum {S_NULL, S_DATA, S_ERR}
- One sub-module, dr_pair_decode: takes (t,f) and returns null, value, illegal. It is instantiated three times.
- The next-count logic stays in the top module.

Test Plan:
- Reset, then WIDTH = 8, SATURATE = 0, CLR_VAL = 0. Five handshakes with en = 1, down = 0 -> t_out = 1..5, f_out = 8'hFE..8'hFA, ackout low in each data phase, all rails 0 in each spacer.
- Count at 8'hFF, up + enable -> wrap mode: t_out = 8'h00, t_tc = 1. Saturate build: t_out = 8'hFF, t_tc = 1. Next up step in saturate mode -> still 8'hFF.
- Count 0, down + enable -> wrap: t_out = 8'hFF, tc = 1. Then clr = 1 with en = 1 in the same handshake -> t_out = CLR_VAL, f_tc = 1 (clear wins).
- t_clr = f_clr = 1 with ackin = 1 -> err = 1, ackout stays 1, count unchanged. Drop ackin and null all pairs -> err = 0. A following valid request counts normally.
- Partial command (enable pair null) with ackin = 1 for 10 cycles -> no update, ackout = 1. Complete the pair -> update 1 cycle later. Hold ackin = 1 for 5 cycles in S_DATA -> single increment only.
- Assert reset while in S_DATA with t_out = 8'h07 -> next cycle: count = CLR_VAL, rails 0, ackout = 1, err = 0.
